// File: rtl/mkio_pkg.sv
// Shared MKIO definitions for the receiver and transmitter: FSM states, line states,
// sync patterns and the parity type.
package mkio_pkg;

  localparam int unsigned HalfBitDefault = 8;
  localparam int unsigned DataBits       = 16;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t StIdle  = 2'd0;
  localparam rx_state_t StSync2 = 2'd1;
  localparam rx_state_t StBits  = 2'd2;
  localparam rx_state_t StDone  = 2'd3;

  // Encoded directly as {DI1, DI0} after synchronisation.
  typedef logic [1:0] line_t;
  localparam line_t LineIdle    = 2'b00;
  localparam line_t LineLow     = 2'b01;
  localparam line_t LineHigh    = 2'b10;
  localparam line_t LineInvalid = 2'b11;

  // Sync patterns in half-bits, MSB sent first (1 = high, 0 = low).
  localparam logic [5:0] SyncCmd  = 6'b000111;
  localparam logic [5:0] SyncData = 6'b111000;

  localparam logic ParityOdd = 1'b1;

  function automatic logic parity_ok(input logic [16:0] word);
    return (^word) == ParityOdd;
  endfunction

endpackage

// File: rtl/mkio_rx_frontend.sv
// Two-flop synchronizer for both line phases; the synchronized pair is the line state.
module mkio_rx_frontend
  import mkio_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  di1,
  input  logic  di0,
  output line_t line
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {di1, di0};
      sync_q <= meta_q;
    end
  end

  assign line = sync_q;

endmodule

// File: rtl/mkio_receiver.sv
// Manchester-II word receiver: run-length sync hunt, then fixed sampling timed from the
// sync edge, odd parity check and one-cycle completion/error strobes.
module mkio_receiver
  import mkio_pkg::*;
#(
  parameter int unsigned HALF_BIT = HalfBitDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DI1,
  input  logic        DI0,
  output logic [15:0] data_rcv,
  output logic        cd_rcv,
  output logic        imp_rcv,
  output logic        err_rcv,
  output logic        busy_rcv
);

  localparam int unsigned RunW = $clog2(5 * HALF_BIT + 2);
  localparam int unsigned TmrW = $clog2(3 * HALF_BIT);
  localparam int unsigned PhW  = $clog2(2 * HALF_BIT);

  localparam logic [RunW-1:0] RunLo    = RunW'(5 * HALF_BIT / 2);
  localparam logic [RunW-1:0] RunHi    = RunW'(5 * HALF_BIT);
  localparam logic [RunW-1:0] RunSat   = RunW'(5 * HALF_BIT + 1);
  localparam logic [TmrW-1:0] TmrCheck = TmrW'(3 * HALF_BIT / 2);
  localparam logic [TmrW-1:0] TmrLast  = TmrW'(3 * HALF_BIT - 1);
  localparam logic [PhW-1:0]  PhFirst  = PhW'(HALF_BIT / 2);
  localparam logic [PhW-1:0]  PhSecond = PhW'(3 * HALF_BIT / 2);
  localparam logic [PhW-1:0]  PhLast   = PhW'(2 * HALF_BIT - 1);
  localparam logic [4:0]      LastBit  = 5'(DataBits);

  line_t line;

  mkio_rx_frontend u_frontend (
    .clk   (clk),
    .reset (reset),
    .di1   (DI1),
    .di0   (DI0),
    .line  (line)
  );

  rx_state_t       state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [4:0]      bit_q, bit_d;
  line_t           first_q, first_d;
  logic [15:0]     shift_q, shift_d;
  logic            cd_cand_q, cd_cand_d;
  logic [RunW-1:0] run_q, run_d;
  line_t           lvl_q, lvl_d;
  logic [15:0]     data_d;
  logic            cd_d, imp_d, err_d;
  logic            sync_edge;
  logic            is_level;
  logic [16:0]     full;
  line_t           post_lvl;

  assign is_level = (line == LineHigh) || (line == LineLow);

  // Run length runs in every state so a back-to-back sync is measured from its true start,
  // including a preceding parity half of the same level.
  always_comb begin
    run_d     = run_q;
    lvl_d     = lvl_q;
    sync_edge = 1'b0;
    if (!is_level) begin
      run_d = '0;
      lvl_d = LineIdle;
    end else if (line == lvl_q) begin
      if (run_q != RunSat) run_d = run_q + 1'b1;
    end else begin
      sync_edge = (lvl_q != LineIdle) && (run_q >= RunLo) && (run_q <= RunHi);
      run_d     = RunW'(1);
      lvl_d     = line;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    first_d   = first_q;
    shift_d   = shift_q;
    cd_cand_d = cd_cand_q;
    data_d    = data_rcv;
    cd_d      = cd_rcv;
    imp_d     = 1'b0;
    err_d     = 1'b0;
    full      = {shift_q, first_q == LineHigh};
    post_lvl  = cd_cand_q ? LineHigh : LineLow;

    case (state_q)
      StIdle: begin
        if (sync_edge) begin
          state_d   = StSync2;
          tmr_d     = TmrW'(1);
          cd_cand_d = (lvl_q == LineLow);
        end
      end
      StSync2: begin
        if (line == LineInvalid) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if ((tmr_q == TmrCheck) && (line != post_lvl)) begin
          state_d = StIdle;
        end else if (tmr_q == TmrLast) begin
          state_d = StBits;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StBits: begin
        ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
        if (ph_q == PhLast) bit_d = bit_q + 5'd1;
        if (line == LineInvalid) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (ph_q == PhFirst) begin
          if (line == LineIdle) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            first_d = line;
          end
        end else if (ph_q == PhSecond) begin
          if ((line == LineIdle) || (line == first_q)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else if (bit_q == LastBit) begin
            state_d = StDone;
            data_d  = full[16:1];
            cd_d    = cd_cand_q;
            imp_d   = 1'b1;
            err_d   = !parity_ok(full);
          end else begin
            shift_d = full[15:0];
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      first_q   <= LineIdle;
      shift_q   <= '0;
      cd_cand_q <= 1'b0;
      run_q     <= '0;
      lvl_q     <= LineIdle;
      data_rcv  <= '0;
      cd_rcv    <= 1'b0;
      imp_rcv   <= 1'b0;
      err_rcv   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      first_q   <= first_d;
      shift_q   <= shift_d;
      cd_cand_q <= cd_cand_d;
      run_q     <= run_d;
      lvl_q     <= lvl_d;
      data_rcv  <= data_d;
      cd_rcv    <= cd_d;
      imp_rcv   <= imp_d;
      err_rcv   <= err_d;
    end
  end

  assign busy_rcv = (state_q == StSync2) || (state_q == StBits);

endmodule

// File: tb/tb_mkio_receiver.sv
// Bench for mkio_receiver: drives Manchester words half-bit by half-bit and checks the
// strobes, fields and timing against expectations derived from the words sent.
module tb_mkio_receiver;
  import mkio_pkg::*;

  localparam int unsigned H = 8;
  // Word start to the imp_rcv sample: sync first half + synchronizer + (t0 -> DONE) + 1.
  localparam int unsigned ImpOff = 3 * H + 2 + (3 * H + 32 * H + 3 * H / 2 + 1) + 1;
  // Word start to err_rcv sample when the whole first half of bit 5 is invalid.
  localparam int unsigned GlitchOff = 16 * H + 2 + 1 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DI1 = 1'b0;
  logic        DI0 = 1'b0;
  logic [15:0] data_rcv;
  logic        cd_rcv, imp_rcv, err_rcv, busy_rcv;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned cyc;
    logic        imp;
    logic        err;
    logic        busy;
    logic [15:0] data;
    logic        cd;
  } ev_t;

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic        cd;
    logic        err;
  } exp_t;

  ev_t         ev_q[$];
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  mkio_receiver #(.HALF_BIT(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .DI1      (DI1),
    .DI0      (DI0),
    .data_rcv (data_rcv),
    .cd_rcv   (cd_rcv),
    .imp_rcv  (imp_rcv),
    .err_rcv  (err_rcv),
    .busy_rcv (busy_rcv)
  );

  always @(negedge clk) begin : monitor
    ev_t e;
    cyc = cyc + 1;
    if (imp_rcv || err_rcv) begin
      e.cyc  = cyc;
      e.imp  = imp_rcv;
      e.err  = err_rcv;
      e.busy = busy_rcv;
      e.data = data_rcv;
      e.cd   = cd_rcv;
      ev_q.push_back(e);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one word; glitch_half marks a half-bit driven invalid, stop_cyc > 0 abandons early.
  task automatic send_word(input logic [15:0] d, input logic cd, input logic bad_par,
                           input int glitch_half, input int stop_cyc);
    logic [39:0] halves;
    logic [5:0]  sync;
    logic        p;
    int          n;
    sync = cd ? SyncCmd : SyncData;
    p = ~(^d);
    if (bad_par) p = ~p;
    for (int i = 0; i < 6; i++) halves[39-i] = sync[5-i];
    for (int k = 0; k < 16; k++) begin
      halves[33-2*k] = d[15-k];
      halves[32-2*k] = ~d[15-k];
    end
    halves[1] = p;
    halves[0] = ~p;
    n = 0;
    for (int h = 0; h < 40; h++) begin
      for (int c = 0; c < int'(H); c++) begin
        if (h == glitch_half) {DI1, DI0} = 2'b11;
        else {DI1, DI0} = halves[39-h] ? 2'b10 : 2'b01;
        hold(1);
        n++;
        if (stop_cyc > 0 && n == stop_cyc) return;
      end
    end
  endtask

  task automatic line_idle(input int n);
    {DI1, DI0} = 2'b00;
    hold(n);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      {DI1, DI0} = 2'($urandom);
      hold(1);
    end
    n_checks++; if (data_rcv !== 16'h0000) begin n_errors++;
      $display("FAIL reset_data: got %h expected 0000", data_rcv); end
    n_checks++; if (cd_rcv !== 1'b0) begin n_errors++;
      $display("FAIL reset_cd: got %b expected 0", cd_rcv); end
    n_checks++; if (imp_rcv !== 1'b0) begin n_errors++;
      $display("FAIL reset_imp: got %b expected 0", imp_rcv); end
    n_checks++; if (err_rcv !== 1'b0) begin n_errors++;
      $display("FAIL reset_err: got %b expected 0", err_rcv); end
    n_checks++; if (busy_rcv !== 1'b0) begin n_errors++;
      $display("FAIL reset_busy: got %b expected 0", busy_rcv); end
    reset = 1'b0;
    line_idle(10);
  endtask

  task automatic test_cmd_word();
    int unsigned c0;
    ev_q.delete();
    c0 = cyc;
    send_word(16'hA5C3, 1'b1, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL cmd_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].imp !== 1'b1) begin n_errors++;
        $display("FAIL cmd_imp: got %b expected 1", ev_q[0].imp); end
      n_checks++; if (ev_q[0].data !== 16'hA5C3) begin n_errors++;
        $display("FAIL cmd_data: got %h expected a5c3", ev_q[0].data); end
      n_checks++; if (ev_q[0].cd !== 1'b1) begin n_errors++;
        $display("FAIL cmd_cd: got %b expected 1", ev_q[0].cd); end
      n_checks++; if (ev_q[0].err !== 1'b0) begin n_errors++;
        $display("FAIL cmd_err: got %b expected 0", ev_q[0].err); end
      n_checks++; if (ev_q[0].cyc - c0 != ImpOff) begin n_errors++;
        $display("FAIL cmd_latency: got %0d expected %0d", ev_q[0].cyc - c0, ImpOff); end
    end
  endtask

  task automatic test_data_zero();
    ev_q.delete();
    send_word(16'h0000, 1'b0, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL zero_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].data !== 16'h0000) begin n_errors++;
        $display("FAIL zero_data: got %h expected 0000", ev_q[0].data); end
      n_checks++; if (ev_q[0].cd !== 1'b0) begin n_errors++;
        $display("FAIL zero_cd: got %b expected 0", ev_q[0].cd); end
      n_checks++; if (ev_q[0].err !== 1'b0 || ev_q[0].imp !== 1'b1) begin n_errors++;
        $display("FAIL zero_strobes: got imp=%b err=%b expected imp=1 err=0",
                 ev_q[0].imp, ev_q[0].err); end
    end
  endtask

  task automatic test_parity_error();
    ev_q.delete();
    send_word(16'h00FF, 1'b1, 1'b1, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL par_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].imp !== 1'b1 || ev_q[0].err !== 1'b1) begin n_errors++;
        $display("FAIL par_strobes: got imp=%b err=%b expected imp=1 err=1",
                 ev_q[0].imp, ev_q[0].err); end
      n_checks++; if (ev_q[0].data !== 16'h00FF) begin n_errors++;
        $display("FAIL par_data: got %h expected 00ff", ev_q[0].data); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    ev_q.delete();
    c0 = cyc;
    send_word(16'h1234, 1'b1, 1'b0, -1, 0);
    send_word(16'hFFFF, 1'b0, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 2) begin n_errors++;
      $display("FAIL b2b_events: got %0d expected 2", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].data !== 16'h1234 || ev_q[0].cd !== 1'b1) begin n_errors++;
        $display("FAIL b2b_first: got %h/%b expected 1234/1", ev_q[0].data, ev_q[0].cd); end
      n_checks++; if (ev_q[1].data !== 16'hFFFF || ev_q[1].cd !== 1'b0) begin n_errors++;
        $display("FAIL b2b_second: got %h/%b expected ffff/0", ev_q[1].data, ev_q[1].cd); end
      n_checks++; if (ev_q[0].err !== 1'b0 || ev_q[1].err !== 1'b0) begin n_errors++;
        $display("FAIL b2b_err: got %b%b expected 00", ev_q[0].err, ev_q[1].err); end
      n_checks++; if (ev_q[1].cyc - ev_q[0].cyc != 320) begin n_errors++;
        $display("FAIL b2b_spacing: got %0d expected 320", ev_q[1].cyc - ev_q[0].cyc); end
      n_checks++; if (ev_q[0].cyc - c0 != ImpOff) begin n_errors++;
        $display("FAIL b2b_latency: got %0d expected %0d", ev_q[0].cyc - c0, ImpOff); end
    end
  endtask

  task automatic test_invalid_glitch();
    int unsigned c0;
    ev_q.delete();
    c0 = cyc;
    send_word(16'h0F0F, 1'b1, 1'b0, 16, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL glitch_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].err !== 1'b1 || ev_q[0].imp !== 1'b0) begin n_errors++;
        $display("FAIL glitch_strobes: got imp=%b err=%b expected imp=0 err=1",
                 ev_q[0].imp, ev_q[0].err); end
      n_checks++; if (ev_q[0].busy !== 1'b0) begin n_errors++;
        $display("FAIL glitch_busy: got %b expected 0", ev_q[0].busy); end
      n_checks++; if (ev_q[0].cyc - c0 != GlitchOff) begin n_errors++;
        $display("FAIL glitch_latency: got %0d expected %0d", ev_q[0].cyc - c0, GlitchOff); end
    end
    ev_q.delete();
    send_word(16'h5555, 1'b0, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].data !== 16'h5555 || ev_q[0].err !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_next_word: got %0d events expected one clean 5555", ev_q.size());
    end
  endtask

  task automatic test_reset_mid_word();
    int unsigned c0;
    ev_q.delete();
    send_word(16'h1357, 1'b1, 1'b0, -1, 3 * H + 2 + 100);
    n_checks++; if (busy_rcv !== 1'b1) begin n_errors++;
      $display("FAIL midrst_busy_before: got %b expected 1", busy_rcv); end
    reset = 1'b1;
    {DI1, DI0} = 2'b00;
    hold(1);
    n_checks++;
    if ({data_rcv, cd_rcv, imp_rcv, err_rcv, busy_rcv} !== 20'h0) begin n_errors++;
      $display("FAIL midrst_outputs: got data=%h cd=%b imp=%b err=%b busy=%b expected all 0",
               data_rcv, cd_rcv, imp_rcv, err_rcv, busy_rcv); end
    reset = 1'b0;
    line_idle(10);
    n_checks++; if (ev_q.size() != 0) begin n_errors++;
      $display("FAIL midrst_strobe: got %0d events expected 0", ev_q.size()); end
    ev_q.delete();
    c0 = cyc;
    send_word(16'hBEEF, 1'b1, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL midrst_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++; if (ev_q[0].data !== 16'hBEEF || ev_q[0].cd !== 1'b1) begin n_errors++;
        $display("FAIL midrst_word: got %h/%b expected beef/1", ev_q[0].data, ev_q[0].cd); end
      n_checks++; if (ev_q[0].cyc - c0 != ImpOff) begin n_errors++;
        $display("FAIL midrst_latency: got %0d expected %0d", ev_q[0].cyc - c0, ImpOff); end
    end
  endtask

  task automatic test_stuck_line();
    int unsigned c0;
    ev_q.delete();
    c0 = cyc;
    {DI1, DI0} = 2'b01;
    hold(60);
    send_word(16'h3C96, 1'b0, 1'b0, -1, 0);
    line_idle(20);
    n_checks++;
    if (ev_q.size() != 1) begin n_errors++;
      $display("FAIL stuck_events: got %0d expected 1", ev_q.size()); end
    else begin
      n_checks++;
      if (ev_q[0].data !== 16'h3C96 || ev_q[0].cd !== 1'b0 || ev_q[0].err !== 1'b0) begin
        n_errors++;
        $display("FAIL stuck_word: got %h/%b/%b expected 3c96/0/0",
                 ev_q[0].data, ev_q[0].cd, ev_q[0].err); end
      n_checks++; if (ev_q[0].cyc - c0 != 60 + ImpOff) begin n_errors++;
        $display("FAIL stuck_latency: got %0d expected %0d", ev_q[0].cyc - c0, 60 + ImpOff); end
    end
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    exp_t x;
    int   gap;
    ev_q.delete();
    for (int i = 0; i < 10; i++) begin
      x.data = 16'($urandom);
      x.cd   = 1'($urandom);
      x.err  = ($urandom_range(0, 3) == 0);
      x.cyc  = cyc + ImpOff;
      exp_q.push_back(x);
      send_word(x.data, x.cd, x.err, -1, 0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      line_idle(gap);
    end
    line_idle(20);
    n_checks++;
    if (ev_q.size() != exp_q.size()) begin n_errors++;
      $display("FAIL rnd_events: got %0d expected %0d", ev_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (ev_q[i].imp !== 1'b1 || ev_q[i].data !== exp_q[i].data ||
            ev_q[i].cd !== exp_q[i].cd || ev_q[i].err !== exp_q[i].err ||
            ev_q[i].cyc != exp_q[i].cyc) begin
          n_errors++;
          $display("FAIL rnd_word%0d: got imp=%b %h/%b/%b @%0d expected imp=1 %h/%b/%b @%0d",
                   i, ev_q[i].imp, ev_q[i].data, ev_q[i].cd, ev_q[i].err, ev_q[i].cyc,
                   exp_q[i].data, exp_q[i].cd, exp_q[i].err, exp_q[i].cyc);
        end
      end
      n_checks++; if (data_rcv !== exp_q[exp_q.size()-1].data) begin n_errors++;
        $display("FAIL rnd_hold: got %h expected %h", data_rcv, exp_q[exp_q.size()-1].data); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_word();
    test_data_zero();
    test_parity_error();
    test_back_to_back();
    test_invalid_glitch();
    test_reset_mid_word();
    test_stuck_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
